mem_responder: RTL

Memory-side responder for the byte-wide multicycle datapath. It accepts single-byte read and write requests from the processor controller and datapath (memread, memwrite, iord-selected address, write data). It services each request after a programmable number of wait states and signals completion with a one-cycle ready pulse. It holds the backing byte array and provides a side-band load port so the bench or boot logic can preload programs.

---
 rtl/mem_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: byte-wide memory responder with programmable wait states.
// A sampled read/write request is latched in IDLE, held through WAIT wait
// cycles, performed on the edge entering RESP, and acknowledged with a
// one-cycle ready pulse. A side-band preload port writes the array directly.
module mem_responder #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 8,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [AWIDTH-1:0] adr,
  input  logic [WIDTH-1:0]  writedata,
  output logic [WIDTH-1:0]  memdata,
  output logic              ready,
  output logic              busy,
  output logic              err,
  input  logic              ld_en,
  input  logic [AWIDTH-1:0] ld_adr,
  input  logic [WIDTH-1:0]  ld_data
);

  typedef enum logic [1:0] {IDLE, WAITST, RESP} state_t;

  localparam logic [3:0] WAIT_M1 = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                req_we_q, req_we_d;
  logic [AWIDTH-1:0]   req_adr_q, req_adr_d;
  logic [WIDTH-1:0]    req_data_q, req_data_d;
  logic                err_q, err_d;
  logic [WIDTH-1:0]    memdata_q, memdata_d;
  logic [WIDTH-1:0]    mem_q [0:(1<<AWIDTH)-1];

  // Transaction performed on the edge entering RESP; with no wait states
  // that edge is the sampling edge itself, so the live inputs are used.
  logic                enter_resp;
  logic                eff_we;
  logic [AWIDTH-1:0]   eff_adr;
  logic [WIDTH-1:0]    eff_data;

  // Next-state, request latching and transaction select.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_we_d   = req_we_q;
    req_adr_d  = req_adr_q;
    req_data_d = req_data_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    eff_we     = req_we_q;
    eff_adr    = req_adr_q;
    eff_data   = req_data_q;
    case (state_q)
      IDLE: begin
        if (memread || memwrite) begin
          // A simultaneous read and write is serviced as a write.
          req_we_d   = memwrite;
          req_adr_d  = adr;
          req_data_d = writedata;
          if (memread && memwrite) err_d = 1'b1;
          if (WAIT == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
            eff_we     = memwrite;
            eff_adr    = adr;
            eff_data   = writedata;
          end else begin
            state_d = WAITST;
            cnt_d   = WAIT_M1;
          end
        end
      end
      WAITST: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    memdata_d = memdata_q;
    if (enter_resp && !eff_we) memdata_d = mem_q[eff_adr];
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      req_we_q   <= 1'b0;
      req_adr_q  <= '0;
      req_data_q <= '0;
      err_q      <= 1'b0;
      memdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_we_q   <= req_we_d;
      req_adr_q  <= req_adr_d;
      req_data_q <= req_data_d;
      err_q      <= err_d;
      memdata_q  <= memdata_d;
    end
  end

  // Backing array: preload first so a same-address request write wins;
  // a request write is dropped when reset lands on its RESP-entry edge.
  always_ff @(posedge clk) begin
    if (ld_en) mem_q[ld_adr] <= ld_data;
    if (!rst && enter_resp && eff_we) mem_q[eff_adr] <= eff_data;
  end

  assign ready   = (state_q == RESP);
  assign busy    = (state_q != IDLE);
  assign memdata = memdata_q;
  assign err     = err_q;

endmodule
